// File: rtl/reg_native_if2mem_pkg.sv
// Shared types for the multi-channel native-register-to-memory bridge:
// FSM state encoding and response error codes.
package reg_native_if2mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOCAL_RSP = 2'd1,
        MEM_WAIT  = 2'd2,
        MEM_RSP   = 2'd3
    } state_t;

    localparam logic ERR_OK      = 1'b0;
    localparam logic ERR_PROTO   = 1'b1;
    localparam logic ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/reg_native_mem_timer.sv
// Loadable down-counter that raises expire in the last allowed MEM_WAIT cycle.
// TIMEOUT_CYCLES == 0 disables the timeout entirely.
module reg_native_mem_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam int LOAD = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CW-1:0] count;
    logic          running;

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            // Loaded one short so expire coincides with the final allowed wait cycle.
            count   <= CW'(LOAD);
            running <= 1'b1;
        end else if (stop) begin
            running <= 1'b0;
        end else if (running && count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expire = (TIMEOUT_CYCLES != 0) && running && (count == '0);

endmodule

// File: rtl/reg_native_if2mem_mc.sv
// Bus-to-wide-memory bridge: assembles/splits wide words through snapshot
// buffers, decodes a channel, checks protocol and times out memory accesses.
module reg_native_if2mem_mc
    import reg_native_if2mem_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 64,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int MEM_ADDR_WIDTH = 5,
    parameter int MEM_NUM        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              native_clk,
    input  logic                              native_rst,
    input  logic                              soft_rst,
    input  logic                              req_vld,
    input  logic [BUS_ADDR_WIDTH-1:0]         addr,
    input  logic                              wr_en,
    input  logic                              rd_en,
    input  logic [BUS_DATA_WIDTH-1:0]         wr_data,
    output logic                              ack_vld,
    output logic                              err,
    output logic [BUS_DATA_WIDTH-1:0]         rd_data,
    output logic [MEM_NUM-1:0]                mem_req_vld,
    input  logic [MEM_NUM-1:0]                mem_ack_vld,
    input  logic [MEM_NUM-1:0]                mem_err,
    output logic [MEM_ADDR_WIDTH-1:0]         mem_addr,
    output logic                              mem_wr_en,
    output logic                              mem_rd_en,
    output logic [MEM_DATA_WIDTH-1:0]         mem_wr_data,
    input  logic [MEM_NUM*MEM_DATA_WIDTH-1:0] mem_rd_data
);

    localparam int RATIO     = MEM_DATA_WIDTH / BUS_DATA_WIDTH;
    localparam int BYTE_BITS = $clog2(BUS_DATA_WIDTH / 8);
    localparam int BEAT_BITS = $clog2(RATIO);
    localparam int ENTRY_LSB = BYTE_BITS + BEAT_BITS;
    localparam int CH_LSB    = ENTRY_LSB + MEM_ADDR_WIDTH;
    localparam int CH_BITS   = $clog2(MEM_NUM);
    localparam int BEAT_W    = (BEAT_BITS > 0) ? BEAT_BITS : 1;
    localparam int CH_W      = (CH_BITS > 0) ? CH_BITS : 1;

    state_t                    state;
    logic                      rst;
    logic [BEAT_W-1:0]         beat;
    logic [CH_W-1:0]           ch;
    logic [CH_W-1:0]           ch_q;
    logic [MEM_DATA_WIDTH-1:0] wr_snap;
    logic [MEM_DATA_WIDTH-1:0] rd_snap;
    logic [MEM_DATA_WIDTH-1:0] wr_word;
    logic [MEM_DATA_WIDTH-1:0] ch_word;
    logic                      accept;
    logic                      proto_err;
    logic                      wr_go;
    logic                      rd_go;
    logic                      ch_ack;
    logic                      ch_err;
    logic                      start;
    logic                      stop;
    logic                      expire;
    logic                      unused_addr;

    assign rst         = native_rst | soft_rst;
    // Byte-lane and upper address bits are decoded upstream.
    assign unused_addr = ^addr;

    if (BEAT_BITS > 0) begin : g_beat
        assign beat = addr[BYTE_BITS +: BEAT_W];
    end else begin : g_no_beat
        assign beat = '0;
    end

    if (CH_BITS > 0) begin : g_ch
        assign ch = addr[CH_LSB +: CH_W];
    end else begin : g_no_ch
        assign ch = '0;
    end

    // NOTE: the top slot is overwritten here, so only the lower slots of wr_snap matter.
    always_comb begin
        wr_word = wr_snap;
        wr_word[(RATIO-1)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = wr_data;
    end

    assign ch_word   = mem_rd_data[ch_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
    assign accept    = (state == IDLE) && req_vld;
    assign proto_err = (wr_en == rd_en);
    assign wr_go     = accept && !proto_err && wr_en && (beat == BEAT_W'(RATIO-1));
    assign rd_go     = accept && !proto_err && rd_en && (beat == '0);
    assign ch_ack    = (state == MEM_WAIT) && mem_ack_vld[ch_q];
    assign ch_err    = mem_err[ch_q];
    assign start     = wr_go | rd_go;
    assign stop      = (state == MEM_WAIT) && (ch_ack || expire);

    reg_native_mem_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (native_clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .expire (expire)
    );

    always_ff @(posedge native_clk) begin
        if (rst) begin
            // NOTE: snapshots are small register files and must read back 0 after reset.
            state       <= IDLE;
            ack_vld     <= 1'b0;
            err         <= ERR_OK;
            rd_data     <= '0;
            mem_req_vld <= '0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_wr_data <= '0;
            wr_snap     <= '0;
            rd_snap     <= '0;
            ch_q        <= '0;
        end else begin
            ack_vld <= 1'b0;
            err     <= ERR_OK;
            rd_data <= '0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (proto_err) begin
                            state   <= LOCAL_RSP;
                            ack_vld <= 1'b1;
                            err     <= ERR_PROTO;
                        end else if (wr_go || rd_go) begin
                            state       <= MEM_WAIT;
                            ch_q        <= ch;
                            mem_req_vld <= MEM_NUM'(1) << ch;
                            mem_addr    <= addr[ENTRY_LSB +: MEM_ADDR_WIDTH];
                            mem_wr_en   <= wr_go;
                            mem_rd_en   <= rd_go;
                            mem_wr_data <= wr_go ? wr_word : '0;
                        end else if (wr_en) begin
                            wr_snap[beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= wr_data;
                            state   <= LOCAL_RSP;
                            ack_vld <= 1'b1;
                        end else begin
                            rd_data <= rd_snap[beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                            state   <= LOCAL_RSP;
                            ack_vld <= 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    // An ack in the final allowed cycle takes priority over expire.
                    if (ch_ack || expire) begin
                        state       <= MEM_RSP;
                        ack_vld     <= 1'b1;
                        mem_req_vld <= '0;
                        mem_addr    <= '0;
                        mem_wr_en   <= 1'b0;
                        mem_rd_en   <= 1'b0;
                        mem_wr_data <= '0;
                        if (ch_ack) begin
                            err <= ch_err;
                            if (mem_rd_en && !ch_err) begin
                                rd_snap <= ch_word;
                                rd_data <= ch_word[BUS_DATA_WIDTH-1:0];
                            end
                        end else begin
                            err <= ERR_TIMEOUT;
                        end
                    end
                end
                LOCAL_RSP, MEM_RSP: state <= IDLE;
                default:            state <= IDLE;
            endcase
        end
    end

endmodule
